regbank_pipe: RTL and testbench

//  Operand-supply and write-back end of the ALU pipeline. Holds the architectural

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/regfile_2r1w.sv | 37 +++
 rtl/regbank_pipe.sv | 106 ++++++++++
 tb/tb_regbank_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants, ALU op encodings and pipeline tag type for the operand/write-back end.
package cpu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;

  // 3-bit ALU operation select carried on S.
  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpXor  = 3'd4,
    OpSll  = 3'd5,
    OpSrl  = 3'd6,
    OpPass = 3'd7
  } alu_op_e;

  // In-flight instruction tag: a bubble carries valid=0 and dest=0.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
  } pipe_tag_t;

  // True when source x is produced by the tagged in-flight instruction; r0 never matches.
  function automatic logic tag_hit(input logic [AW-1:0] x, input pipe_tag_t t);
    return t.valid && (t.dest == x) && (x != '0);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 fixed at zero.
module regfile_2r1w #(
  parameter int unsigned Width = 32,
  parameter int unsigned NReg  = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AddrW-1:0] ra,
  input  logic [AddrW-1:0] rb,
  output logic [Width-1:0] rdata_a,
  output logic [Width-1:0] rdata_b,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata
);

  logic [Width-1:0] mem [NReg];

  // Storage: cleared on reset, written on posedge; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NReg; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: r0 always returns zero.
  always_comb begin
    rdata_a = (ra == '0) ? '0 : mem[ra];
    rdata_b = (rb == '0) ? '0 : mem[rb];
  end

endmodule

// File: rtl/regbank_pipe.sv
// Operand supply and write-back end of the ALU pipeline: reads sources, forwards the
// result currently on dbus, stalls on older in-flight producers, and writes results back.
module regbank_pipe
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [AW-1:0]    rsa,
  input  logic [AW-1:0]    rsb,
  input  logic [AW-1:0]    rd,
  input  logic [2:0]       op,
  output logic             stall,
  output logic [WIDTH-1:0] abus,
  output logic [WIDTH-1:0] bbus,
  output logic [2:0]       S,
  input  logic [WIDTH-1:0] dbus,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr
);

  pipe_tag_t        s1, s2, s3;
  logic [WIDTH-1:0] rf_a, rf_b;
  logic [WIDTH-1:0] opnd_a, opnd_b;
  logic [2:0]       op_q;
  logic             issue;

  regfile_2r1w #(
    .Width (WIDTH),
    .NReg  (NREG),
    .AddrW (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (rsa),
    .rb      (rsb),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (s3.valid),
    .waddr   (s3.dest),
    .wdata   (dbus)
  );

  // Hazard detect: a source produced by s1 or s2 is not yet on dbus, so refuse the issue.
  // s3 is excluded because its result is forwarded from dbus this cycle.
  always_comb begin
    stall = iss_valid && (tag_hit(rsa, s1) || tag_hit(rsa, s2) ||
                          tag_hit(rsb, s1) || tag_hit(rsb, s2));
    issue = iss_valid && !stall;
  end

  // Forward mux: r0 is zero; a source written back at this same edge takes dbus.
  always_comb begin
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (rsa == '0) begin
      opnd_a = '0;
    end else if (tag_hit(rsa, s3)) begin
      opnd_a = dbus;
    end
    if (rsb == '0) begin
      opnd_b = '0;
    end else if (tag_hit(rsb, s3)) begin
      opnd_b = dbus;
    end
  end

  // Tag shift register: stalls and idle cycles inject a bubble at s1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= issue ? '{valid: 1'b1, dest: rd} : '0;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Operand and op registers: load only on an accepted issue, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abus <= '0;
      bbus <= '0;
      op_q <= '0;
    end else if (issue) begin
      abus <= opnd_a;
      bbus <= opnd_b;
      op_q <= op;
    end
  end

  // S lags op by one more edge so it is valid when the ALU stage latches abus/bbus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S <= '0;
    end else begin
      S <= op_q;
    end
  end

  assign wb_valid = s3.valid;
  assign wb_addr  = s3.dest;

endmodule

// File: tb/tb_regbank_pipe.sv
// Self-checking bench for regbank_pipe: directed scenarios plus randomized issue streams
// compared against a cycle-indexed issue-history model.
module tb_regbank_pipe;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             iss_valid;
  logic [AW-1:0]    rsa, rsb, rd;
  logic [2:0]       op;
  logic             stall;
  logic [WIDTH-1:0] abus, bbus;
  logic [2:0]       S;
  logic [WIDTH-1:0] dbus;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;

  regbank_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .rsa       (rsa),
    .rsb       (rsb),
    .rd        (rd),
    .op        (op),
    .stall     (stall),
    .abus      (abus),
    .bbus      (bbus),
    .S         (S),
    .dbus      (dbus),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: architectural registers plus a record of what was accepted in each cycle.
  // An instruction accepted in cycle c writes its register at the end of cycle c+3.
  logic [31:0] mregs [32];
  logic        hv  [4];
  logic [4:0]  hrd [4];
  int          cyc;
  logic [31:0] ea, eb;
  logic [2:0]  eopq, es;

  function automatic logic model_hit(input int k, input logic [4:0] x);
    int idx;
    idx = (cyc + 4 - k) % 4;
    return hv[idx] && (x != 5'd0) && (hrd[idx] == x);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 4; i++) begin
      hv[i]  = 1'b0;
      hrd[i] = '0;
    end
    cyc = 0; ea = '0; eb = '0; eopq = '0; es = '0;
  endtask

  // One clock cycle; starts and ends 1 time unit after a posedge.
  task automatic step(input logic iv, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [2:0] o, input logic [31:0] db,
                      output logic acc);
    logic       exp_stall, wv;
    logic [4:0] wa;
    int         s3i;
    iss_valid = iv; rsa = a; rsb = b; rd = d; op = o; dbus = db;
    s3i = (cyc + 1) % 4;
    wv  = hv[s3i];
    wa  = hrd[s3i];
    exp_stall = iv && (model_hit(1, a) || model_hit(2, a) || model_hit(1, b) || model_hit(2, b));
    @(negedge clk);
    check_eq("stall", {31'd0, stall}, {31'd0, exp_stall});
    check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, wv});
    check_eq("wb_addr", {27'd0, wb_addr}, {27'd0, wa});
    @(posedge clk);
    if (wv && (wa != 5'd0)) mregs[wa] = db;
    acc = iv && !exp_stall;
    es  = eopq;
    if (acc) begin
      ea   = (a == 5'd0) ? 32'd0 : mregs[a];
      eb   = (b == 5'd0) ? 32'd0 : mregs[b];
      eopq = o;
    end
    hv[cyc % 4]  = acc;
    hrd[cyc % 4] = acc ? d : 5'd0;
    cyc++;
    #1;
    check_eq("abus", abus, ea);
    check_eq("bbus", bbus, eb);
    check_eq("S", {29'd0, S}, {29'd0, es});
  endtask

  // Retry an issue while stalled, holding the inputs; never more than 2 stall cycles.
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic [2:0] o, input logic [31:0] db, output int nstall);
    logic acc;
    nstall = 0;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, a, b, d, o, db, acc);
      if (acc) break;
      nstall++;
    end
    check_eq("stall_bound", {31'd0, (nstall <= 2)}, 32'd1);
  endtask

  task automatic bubble(input logic [31:0] db);
    logic acc;
    step(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, db, acc);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    iss_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check_eq("rst_abus", abus, 32'd0);
    check_eq("rst_bbus", bbus, 32'd0);
    check_eq("rst_S", {29'd0, S}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int          ns;
  logic [31:0] dv;

  initial begin
    iss_valid = 1'b0; rsa = '0; rsb = '0; rd = '0; op = '0; dbus = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // First issue after reset: zero operands, no stall, write-back tag two edges later.
    issue(5'd0, 5'd0, 5'd1, 3'd2, 32'h11, ns);
    check_eq("first_issue_stalls", ns, 0);
    bubble(32'h11);
    bubble(32'h11);
    bubble(32'h11);

    // Write 0xAA into r3, then read it back through the register file.
    issue(5'd0, 5'd0, 5'd3, 3'd1, 32'h0, ns);
    bubble(32'hAA);
    bubble(32'hAA);
    bubble(32'hAA);
    issue(5'd3, 5'd0, 5'd0, 3'd0, 32'h0, ns);
    check_eq("r3_readback", abus, 32'hAA);
    check_eq("r3_nostall", ns, 0);
    bubble(32'h0);
    bubble(32'h0);

    // Back-to-back dependency: two stall cycles, then dbus forwarded into abus.
    issue(5'd0, 5'd0, 5'd5, 3'd3, 32'h0, ns);
    dv = 32'hDEAD_BEEF;
    issue(5'd5, 5'd0, 5'd6, 3'd4, dv, ns);
    check_eq("raw_adjacent_stalls", ns, 2);
    check_eq("raw_adjacent_fwd", abus, dv);
    bubble(32'h0);
    bubble(32'h0);
    bubble(32'h0);

    // One bubble between producer and consumer: one stall cycle, forward into bbus.
    issue(5'd0, 5'd0, 5'd5, 3'd5, 32'h0, ns);
    bubble(32'h0);
    dv = 32'h1234_5678;
    issue(5'd0, 5'd5, 5'd0, 3'd6, dv, ns);
    check_eq("raw_gap_stalls", ns, 1);
    check_eq("raw_gap_fwd", bbus, dv);
    bubble(32'h0);
    bubble(32'h0);
    bubble(32'h0);

    // rd=0 with all-ones result: r0 stays zero and never causes a stall.
    issue(5'd0, 5'd0, 5'd0, 3'd7, 32'hFFFF_FFFF, ns);
    issue(5'd0, 5'd0, 5'd0, 3'd7, 32'hFFFF_FFFF, ns);
    check_eq("r0_no_stall", ns, 0);
    bubble(32'hFFFF_FFFF);
    bubble(32'hFFFF_FFFF);
    issue(5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, ns);
    check_eq("r0_reads_zero", abus, 32'd0);

    // Reset with three write-backs in flight; every register must read zero afterwards.
    issue(5'd0, 5'd0, 5'd1, 3'd0, 32'h0, ns);
    issue(5'd0, 5'd0, 5'd2, 3'd0, 32'h0, ns);
    issue(5'd0, 5'd0, 5'd3, 3'd0, 32'h0, ns);
    do_reset();
    for (int i = 1; i < 32; i++) begin
      issue(i[4:0], 5'(31 - i), 5'd0, 3'd0, 32'hCAFE_F00D, ns);
    end

    // Randomized stream biased toward r0..r7 so dependencies are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, b, d;
      if ($urandom_range(3) == 0) begin
        bubble($urandom);
      end else begin
        a = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
        b = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
        d = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
        issue(a, b, d, 3'($urandom_range(7)), $urandom, ns);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
